// File: rtl/event_seq_pkg.sv
// rtl/event_seq_pkg.sv - shared state encodings and width helpers for the event handshake sequencer
package event_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    FIRE,
    WAIT_E2,
    DONE
  } prod_state_e;

  typedef enum logic [1:0] {
    C_IDLE,
    C_WAIT,
    C_ACK
  } cons_state_e;

  function automatic int round_w(input int rounds);
    return $clog2(rounds + 1);
  endfunction

  // The delay counter holds ACK_DELAY-2 at most; keep at least one bit.
  function automatic int dly_w(input int ack_delay);
    return (ack_delay <= 2) ? 1 : $clog2(ack_delay);
  endfunction

endpackage

// File: rtl/event_seq_chan.sv
// rtl/event_seq_chan.sv - one channel: producer/consumer FSMs, value v and strobe register
module event_seq_chan
  import event_seq_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ROUNDS    = 3,
  parameter int ACK_DELAY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic              en_i,
  output logic              e1_o,
  output logic              e2_o,
  output logic              strobe_vld_o,
  output logic [DATA_W-1:0] strobe_val_o,
  output logic              complete_o
);

  localparam int RW = round_w(ROUNDS);
  localparam int DW = dly_w(ACK_DELAY);
  localparam logic [RW-1:0] ROUNDS_L = RW'(ROUNDS);
  localparam logic [DW-1:0] DLY_LOAD = (ACK_DELAY >= 2) ? DW'(ACK_DELAY - 2) : '0;

  prod_state_e       p_state_q, p_state_d;
  cons_state_e       c_state_q, c_state_d;
  logic [RW-1:0]     rounds_q, rounds_d;
  logic [DW-1:0]     cnt_q, cnt_d;
  logic              en_q, en_d;
  logic [DATA_W-1:0] v_q, v_d;
  logic              strobe_vld_q, strobe_vld_d;
  logic [DATA_W-1:0] strobe_val_q, strobe_val_d;
  logic              last_round;

  assign last_round = (rounds_q == ROUNDS_L);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_state_q    <= IDLE;
      c_state_q    <= C_IDLE;
      rounds_q     <= '0;
      cnt_q        <= '0;
      en_q         <= 1'b0;
      v_q          <= '0;
      strobe_vld_q <= 1'b0;
      strobe_val_q <= '0;
    end else begin
      p_state_q    <= p_state_d;
      c_state_q    <= c_state_d;
      rounds_q     <= rounds_d;
      cnt_q        <= cnt_d;
      en_q         <= en_d;
      v_q          <= v_d;
      strobe_vld_q <= strobe_vld_d;
      strobe_val_q <= strobe_val_d;
    end
  end

  always_comb begin
    p_state_d    = p_state_q;
    c_state_d    = c_state_q;
    rounds_d     = rounds_q;
    cnt_d        = cnt_q;
    en_d         = en_q;
    v_d          = v_q;
    strobe_vld_d = 1'b0;
    strobe_val_d = strobe_val_q;

    if (start_i) begin
      en_d      = en_i;
      rounds_d  = '0;
      c_state_d = C_IDLE;
      if (en_i) begin
        p_state_d = ARM;
        v_d       = '0;
      end else begin
        p_state_d = IDLE;
      end
    end else begin
      // The consumer's update lands even in an aborted e1 cycle; only the pulses are cancelled.
      if (p_state_q == FIRE) begin
        v_d = v_q + DATA_W'(1);
      end
      if (abort_i) begin
        p_state_d = IDLE;
        c_state_d = C_IDLE;
      end else begin
        case (p_state_q)
          ARM: p_state_d = FIRE;
          FIRE: begin
            p_state_d    = WAIT_E2;
            rounds_d     = rounds_q + RW'(1);
            strobe_vld_d = 1'b1;
            strobe_val_d = v_q + DATA_W'(1);
          end
          WAIT_E2: begin
            if (c_state_q == C_ACK) begin
              p_state_d = last_round ? DONE : FIRE;
            end
          end
          default: ;
        endcase

        case (c_state_q)
          C_IDLE: begin
            if (p_state_q == FIRE) begin
              if (ACK_DELAY == 1) begin
                c_state_d = C_ACK;
              end else begin
                c_state_d = C_WAIT;
                cnt_d     = DLY_LOAD;
              end
            end
          end
          C_WAIT: begin
            if (cnt_q == '0) begin
              c_state_d = C_ACK;
            end else begin
              cnt_d = cnt_q - DW'(1);
            end
          end
          default: c_state_d = C_IDLE;
        endcase
      end
    end
  end

  assign e1_o         = (p_state_q == FIRE);
  assign e2_o         = (c_state_q == C_ACK);
  assign strobe_vld_o = strobe_vld_q;
  assign strobe_val_o = strobe_val_q;
  // Reports completion one cycle early so the top can raise done_o as the last e2 ends.
  assign complete_o   = ~en_q | (p_state_q == DONE) |
                        ((p_state_q == WAIT_E2) & (c_state_q == C_ACK) & last_round);

endmodule

// File: rtl/event_handshake_seq.sv
// rtl/event_handshake_seq.sv - multi-channel event handshake sequencer top; EVT_STROBE_LOG_EN enables $strobe logging
module event_handshake_seq
  import event_seq_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int DATA_W    = 8,
  parameter int ROUNDS    = 3,
  parameter int ACK_DELAY = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_i,
  input  logic                     abort_i,
  input  logic [NUM_CH-1:0]        ch_en_i,
  output logic [NUM_CH-1:0]        e1_o,
  output logic [NUM_CH-1:0]        e2_o,
  output logic [NUM_CH-1:0]        strobe_vld_o,
  output logic [NUM_CH*DATA_W-1:0] strobe_val_o,
  output logic                     busy_o,
  output logic                     done_o
);

  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              accept;
  logic              abort_act;
  logic              all_complete;
  logic [NUM_CH-1:0] complete;

  assign accept       = start_i & ~busy_q & ~abort_i;
  assign abort_act    = abort_i & busy_q;
  assign all_complete = &complete;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  always_comb begin
    busy_d = busy_q;
    done_d = done_q;
    if (accept) begin
      busy_d = 1'b1;
      done_d = 1'b0;
    end else if (abort_act) begin
      busy_d = 1'b0;
      done_d = 1'b0;
    end else if (busy_q && all_complete) begin
      busy_d = 1'b0;
      done_d = 1'b1;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    event_seq_chan #(
      .DATA_W   (DATA_W),
      .ROUNDS   (ROUNDS),
      .ACK_DELAY(ACK_DELAY)
    ) u_chan (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_i     (accept),
      .abort_i     (abort_act),
      .en_i        (ch_en_i[c]),
      .e1_o        (e1_o[c]),
      .e2_o        (e2_o[c]),
      .strobe_vld_o(strobe_vld_o[c]),
      .strobe_val_o(strobe_val_o[c*DATA_W +: DATA_W]),
      .complete_o  (complete[c])
    );

`ifdef EVT_STROBE_LOG_EN
    always @(posedge clk) begin
      if (e1_o[c]) $strobe("ch%0d v = %0d", c, strobe_val_o[c*DATA_W +: DATA_W]);
    end
`endif
  end

`ifdef EVT_STROBE_LOG_EN
  logic done_prev_q;
  always @(posedge clk) begin
    done_prev_q <= done_q;
    if (done_q && !done_prev_q) $write("*-* All Finished *-*\n");
  end
`endif

  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule

// File: tb/tb_event_handshake_seq.sv
// tb/tb_event_handshake_seq.sv - randomized scoreboard bench for event_handshake_seq
module tb_event_handshake_seq;

  localparam int NUM_CH    = 2;
  localparam int DATA_W    = 2;
  localparam int ROUNDS    = 5;
  localparam int ACK_DELAY = 3;
  localparam int MAXC      = 6000;
  localparam int MODV      = 1 << DATA_W;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     start_i = 1'b0;
  logic                     abort_i = 1'b0;
  logic [NUM_CH-1:0]        ch_en_i = '0;
  logic [NUM_CH-1:0]        e1_o, e2_o, strobe_vld_o;
  logic [NUM_CH*DATA_W-1:0] strobe_val_o;
  logic                     busy_o, done_o;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  bit exp_busy[MAXC];
  bit exp_done[MAXC];
  int e1_q[NUM_CH][$];
  int e2_q[NUM_CH][$];
  int st_c[NUM_CH][$];
  int st_v[NUM_CH][$];

  event_handshake_seq #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .ROUNDS(ROUNDS), .ACK_DELAY(ACK_DELAY)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i), .ch_en_i(ch_en_i),
    .e1_o(e1_o), .e2_o(e2_o), .strobe_vld_o(strobe_vld_o), .strobe_val_o(strobe_val_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && rst_n && cyc < MAXC) begin
      chk("busy", int'(busy_o), int'(exp_busy[cyc]));
      chk("done", int'(done_o), int'(exp_done[cyc]));
      for (int c = 0; c < NUM_CH; c++) begin
        if (e1_o[c]) begin
          if (e1_q[c].size() == 0) chk("e1_unexpected", cyc, -1);
          else chk("e1_cycle", cyc, e1_q[c].pop_front());
        end
        if (e2_o[c]) begin
          if (e2_q[c].size() == 0) chk("e2_unexpected", cyc, -1);
          else chk("e2_cycle", cyc, e2_q[c].pop_front());
        end
        if (strobe_vld_o[c]) begin
          if (st_c[c].size() == 0) chk("strobe_unexpected", cyc, -1);
          else begin
            chk("strobe_cycle", cyc, st_c[c].pop_front());
            chk("strobe_val", int'(strobe_val_o[c*DATA_W +: DATA_W]), st_v[c].pop_front());
          end
        end
      end
    end
  end

  // Model: events of round r sit at fixed offsets from the accepted start;
  // an abort or reset simply truncates everything after its cut-off cycle.
  task automatic run_one(input logic [NUM_CH-1:0] en, input bit do_abort, input bit do_rst);
    int t, endc, endb, a, cut, s, gap, stop, e1c;
    bit spur, drop;
    t    = cyc;
    endc = t + 2 + ((en == '0) ? 0 : ROUNDS * (ACK_DELAY + 1));
    a    = do_abort ? int'($urandom_range(endc - 1, t + 1)) : 0;
    if (do_abort)    cut = a + 1;
    else if (do_rst) cut = t + 3;
    else             cut = MAXC;
    endb = do_abort ? a + 1 : (do_rst ? t + 3 : endc);
    for (int c = 0; c < NUM_CH; c++) begin
      if (en[c]) begin
        for (int r = 0; r < ROUNDS; r++) begin
          e1c = t + 2 + r * (ACK_DELAY + 1);
          if (e1c < cut) e1_q[c].push_back(e1c);
          if (e1c + ACK_DELAY < cut) e2_q[c].push_back(e1c + ACK_DELAY);
          if (e1c + 1 < cut) begin
            st_c[c].push_back(e1c + 1);
            st_v[c].push_back((r + 1) % MODV);
          end
        end
      end
    end
    for (int k = t + 1; k < endb; k++) exp_busy[k] = 1'b1;
    for (int k = t + 1; k < MAXC; k++) exp_done[k] = 1'b0;
    if (!do_abort && !do_rst) for (int k = endc; k < MAXC; k++) exp_done[k] = 1'b1;

    s    = int'($urandom_range(endb - 1, t + 1));
    spur = 1'($urandom_range(1, 0));
    gap  = do_rst ? 0 : int'($urandom_range(3, 0));
    drop = 1'($urandom_range(1, 0));
    stop = do_rst ? t + 3 : endb + gap;
    for (int k = t; k < stop; k++) begin
      start_i = (k == t) || (spur && k == s) || (drop && gap > 0 && k == endb);
      abort_i = (do_abort && k == a) || (drop && gap > 0 && k == endb);
      ch_en_i = (k == t) ? en : NUM_CH'($urandom);
      @(posedge clk);
      #1;
    end
    start_i = 1'b0;
    abort_i = 1'b0;
    if (do_rst) begin
      #1 rst_n = 1'b0;
      #1;
      chk("rst_e1", int'(e1_o), 0);
      chk("rst_e2", int'(e2_o), 0);
      chk("rst_strobe_vld", int'(strobe_vld_o), 0);
      chk("rst_strobe_val", int'(strobe_val_o), 0);
      chk("rst_busy", int'(busy_o), 0);
      chk("rst_done", int'(done_o), 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_e1", int'(e1_o), 0);
    chk("reset_e2", int'(e2_o), 0);
    chk("reset_strobe_vld", int'(strobe_vld_o), 0);
    chk("reset_strobe_val", int'(strobe_val_o), 0);
    chk("reset_busy", int'(busy_o), 0);
    chk("reset_done", int'(done_o), 0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    run_one(2'b11, 1'b0, 1'b0);
    run_one(2'b10, 1'b0, 1'b0);
    run_one(2'b00, 1'b0, 1'b0);
    run_one(2'b01, 1'b1, 1'b0);
    run_one(2'b11, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      run_one(NUM_CH'($urandom), ($urandom_range(3, 0) == 0), 1'b0);
    end
    run_one(2'b11, 1'b0, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    for (int c = 0; c < NUM_CH; c++) begin
      chk("e1_missing", e1_q[c].size(), 0);
      chk("e2_missing", e2_q[c].size(), 0);
      chk("strobe_missing", st_c[c].size(), 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
